// File: rtl/fp_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_seq
// Purpose  : Multi-cycle IEEE-754 single-precision adder. A shared datapath
//            is stepped through compare/swap, alignment, add/subtract,
//            normalization and round/pack, one FSM state per phase.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : clk       - rising-edge clock
//            rst       - synchronous active-high reset
//            in_valid  - operands on A/B valid
//            in_ready  - block can accept operands (IDLE only)
//            A, B      - 32-bit operands
//            out_valid - result valid, held until accepted
//            out_ready - consumer accepts result
//            result    - A+B, stable while out_valid
//            busy      - high in every state except IDLE
// Config   : FPADD_RNE_EN - defined: round-to-nearest-even in RND;
//                           undefined: truncate (same latency).
// ============================================================================
module fp_add_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);
    localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMP   = 3'd1,
        S_SHIFT = 3'd2,
        S_ADD   = 3'd3,
        S_NORM  = 3'd4,
        S_RND   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        sign_l_q, sign_l_d, sign_s_q, sign_s_d;
    logic        neg0_q, neg0_d;          // both inputs are -0
    logic [9:0]  exp_q, exp_d;            // wide enough for exp+1 overflow checks
    logic [26:0] ml_q, ml_d, ms_q, ms_d;  // {hidden, frac[22:0], G, R, S}
    logic [4:0]  d_q, d_d;
    logic [27:0] sum_q, sum_d;
    logic [31:0] result_q, result_d;
    logic        out_valid_q, out_valid_d;

    // ---------------- unpack / compare (used in CMP) ----------------
    logic [7:0]  w_ea, w_eb, w_ediff;
    logic [26:0] w_ma, w_mb;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_is_l;
    logic [4:0]  w_dsat;

    assign w_ea     = a_q[30:23];
    assign w_eb     = b_q[30:23];
    // Exponent 0 is treated as zero: denormal fractions are flushed.
    assign w_ma     = (w_ea == 8'd0) ? 27'd0 : {1'b1, a_q[22:0], 3'b000};
    assign w_mb     = (w_eb == 8'd0) ? 27'd0 : {1'b1, b_q[22:0], 3'b000};
    assign w_a_nan  = (w_ea == 8'hFF) && (a_q[22:0] != 23'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (b_q[22:0] != 23'd0);
    assign w_a_inf  = (w_ea == 8'hFF) && (a_q[22:0] == 23'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (b_q[22:0] == 23'd0);
    // Ties resolve to A as the larger operand.
    assign w_a_is_l = {w_ea, w_ma} >= {w_eb, w_mb};
    assign w_ediff  = w_a_is_l ? (w_ea - w_eb) : (w_eb - w_ea);
    assign w_dsat   = (w_ediff > 8'd27) ? 5'd27 : w_ediff[4:0];

    // ---------------- rounding (used in RND) ----------------
    logic        w_rnd_up;
    logic [24:0] w_rnd_sum;
    logic [9:0]  w_exp_r;
    logic [22:0] w_frac_r;

`ifdef FPADD_RNE_EN
    assign w_rnd_up = sum_q[2] && (sum_q[1] || sum_q[0] || sum_q[3]);
`else
    assign w_rnd_up = 1'b0;
`endif
    assign w_rnd_sum = {1'b0, sum_q[26:3]} + {24'd0, w_rnd_up};
    // A carry out of the 24-bit mantissa means it became 1.0 x 2^(e+1).
    assign w_exp_r   = exp_q + {9'd0, w_rnd_sum[24]};
    assign w_frac_r  = w_rnd_sum[24] ? 23'd0 : w_rnd_sum[22:0];

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_l_d    = sign_l_q;
        sign_s_d    = sign_s_q;
        neg0_d      = neg0_q;
        exp_d       = exp_q;
        ml_d        = ml_q;
        ms_d        = ms_q;
        d_d         = d_q;
        sum_d       = sum_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if ((w_ea == 8'hFF) || (w_eb == 8'hFF)) begin
                    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a_q[31] != b_q[31])))
                        result_d = c_QNAN;
                    else if (w_a_inf)
                        result_d = a_q;
                    else
                        result_d = b_q;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    sign_l_d = w_a_is_l ? a_q[31] : b_q[31];
                    sign_s_d = w_a_is_l ? b_q[31] : a_q[31];
                    exp_d    = {2'b00, (w_a_is_l ? w_ea : w_eb)};
                    ml_d     = w_a_is_l ? w_ma : w_mb;
                    ms_d     = w_a_is_l ? w_mb : w_ma;
                    d_d      = w_dsat;
                    neg0_d   = a_q[31] && (w_ea == 8'd0) && b_q[31] && (w_eb == 8'd0);
                    state_d  = (w_dsat == 5'd0) ? S_ADD : S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Bit shifted out of S is folded into the new sticky bit.
                ms_d = {1'b0, ms_q[26:2], ms_q[1] | ms_q[0]};
                d_d  = d_q - 5'd1;
                if (d_q == 5'd1)
                    state_d = S_ADD;
            end
            S_ADD: begin
                if (sign_l_q == sign_s_q)
                    sum_d = {1'b0, ml_q} + {1'b0, ms_q};
                else
                    sum_d = {1'b0, ml_q} - {1'b0, ms_q};
                state_d = S_NORM;
            end
            S_NORM: begin
                if (sum_q == 28'd0) begin
                    result_d    = {neg0_q, 31'd0};
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (sum_q[27]) begin
                    // A carry-out right shift always lands bit 26 set, so the
                    // value is normalized and RND follows directly.
                    sum_d   = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + 10'd1;
                    state_d = S_RND;
                end else if (!sum_q[26] && (exp_q > 10'd1)) begin
                    sum_d = {sum_q[26:0], 1'b0};
                    exp_d = exp_q - 10'd1;
                end else if (!sum_q[26]) begin
                    result_d    = {sign_l_q, 31'd0};
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_RND;
                end
            end
            S_RND: begin
                if (w_exp_r >= 10'd255)
                    result_d = {sign_l_q, 8'hFF, 23'd0};
                else
                    result_d = {sign_l_q, w_exp_r[7:0], w_frac_r};
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            sign_l_q    <= 1'b0;
            sign_s_q    <= 1'b0;
            neg0_q      <= 1'b0;
            exp_q       <= 10'd0;
            ml_q        <= 27'd0;
            ms_q        <= 27'd0;
            d_q         <= 5'd0;
            sum_q       <= 28'd0;
            result_q    <= 32'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_l_q    <= sign_l_d;
            sign_s_q    <= sign_s_d;
            neg0_q      <= neg0_d;
            exp_q       <= exp_d;
            ml_q        <= ml_d;
            ms_q        <= ms_d;
            d_q         <= d_d;
            sum_q       <= sum_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
`default_nettype wire
